// File: rtl/mod997_pkg.sv
// mod997_pkg: shared constants, types and canonicalisation helper for the mod-997 residue path.
package mod997_pkg;
    localparam int MOD997     = 997;
    localparam int RES_W      = 10;
    localparam int NUM_CHUNKS = 84;
    localparam int CNT_W      = 7;

    typedef logic [RES_W-1:0] residue_t;
    typedef enum logic [0:0] {ACC = 1'b0, DONE = 1'b1} state_e;

    localparam residue_t         MOD_R    = residue_t'(MOD997);
    localparam logic [RES_W:0]   MOD_W    = {1'b0, MOD_R};
    localparam logic [CNT_W:0]   LAST_CNT = (CNT_W+1)'(NUM_CHUNKS);

    // Inputs are below 2^RES_W < 2*MOD997, so one subtract always canonicalises.
    function automatic residue_t canon(input residue_t r);
        return (r >= MOD_R) ? r - MOD_R : r;
    endfunction
endpackage

// File: rtl/mod997_add.sv
// mod997_add: combinational (a+b) mod 997 for canonical residues.
module mod997_add
    import mod997_pkg::*;
(
    input  residue_t a_i,
    input  residue_t b_i,
    output residue_t sum_o
);
    logic [RES_W:0] s;
    assign s     = {1'b0, a_i} + {1'b0, b_i};
    assign sum_o = (s >= MOD_W) ? residue_t'(s - MOD_W) : s[RES_W-1:0];
endmodule

// File: rtl/mod997_residue_accum.sv
// mod997_residue_accum: serial mod-997 accumulator of chunk residues with valid/ready in and out.
// Define MOD997_ACCUM_CNT_CHECK_EN to enable beat counting and the out_err_o mismatch flag.
module mod997_residue_accum
    import mod997_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     in_valid_i,
    output logic     in_ready_o,
    input  residue_t in_residue_i,
    input  logic     in_last_i,
    input  logic     flush_i,
    output logic     out_valid_o,
    input  logic     out_ready_i,
    output residue_t out_residue_o,
    output logic     out_err_o
);
    state_e   state_q, state_d;
    residue_t acc_q, acc_d, acc_next;
    residue_t out_residue_q, out_residue_d;
    logic     out_valid_q, out_valid_d;
    logic     beat;

    assign in_ready_o    = (state_q == ACC);
    assign beat          = in_valid_i & in_ready_o;
    assign out_valid_o   = out_valid_q;
    assign out_residue_o = out_residue_q;

    mod997_add u_add (
        .a_i   (acc_q),
        .b_i   (canon(in_residue_i)),
        .sum_o (acc_next)
    );

    // Flush outranks both an incoming beat and an output handshake.
    always_comb begin
        state_d       = state_q;
        acc_d         = acc_q;
        out_valid_d   = out_valid_q;
        out_residue_d = out_residue_q;
        if (flush_i) begin
            state_d     = ACC;
            acc_d       = '0;
            out_valid_d = 1'b0;
        end else if (state_q == ACC) begin
            if (beat) begin
                acc_d = acc_next;
                if (in_last_i) begin
                    out_residue_d = acc_next;
                    out_valid_d   = 1'b1;
                    state_d       = DONE;
                end
            end
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
            acc_d       = '0;
            state_d     = ACC;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ACC;
            acc_q         <= '0;
            out_valid_q   <= 1'b0;
            out_residue_q <= '0;
        end else begin
            state_q       <= state_d;
            acc_q         <= acc_d;
            out_valid_q   <= out_valid_d;
            out_residue_q <= out_residue_d;
        end
    end

`ifdef MOD997_ACCUM_CNT_CHECK_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W:0]   cnt_p1;
    logic             hit, err_q, err_d, out_err_q, out_err_d;

    assign cnt_p1    = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
    assign hit       = (cnt_p1 == LAST_CNT);
    assign out_err_o = out_err_q;

    always_comb begin
        cnt_d     = cnt_q;
        err_d     = err_q;
        out_err_d = out_err_q;
        if (flush_i) begin
            cnt_d     = '0;
            err_d     = 1'b0;
            out_err_d = 1'b0;
        end else if (beat) begin
            cnt_d = (&cnt_q) ? cnt_q : cnt_p1[CNT_W-1:0];
            err_d = err_q | (~in_last_i & hit);
            if (in_last_i) out_err_d = ~hit | err_q;
        end else if (state_q == DONE && out_ready_i) begin
            cnt_d = '0;
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            err_q     <= 1'b0;
            out_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            out_err_q <= out_err_d;
        end
    end
`else
    assign out_err_o = 1'b0;
`endif
endmodule

// File: doc/mod997_residue_accum.md
Name: mod997_residue_accum

Overview:
- Sequential consumer of the 10-bit residues produced by the 6-input chunk LUT stages in the mod-997 reduction of a 500-bit operand.
- Each LUT stage maps one 6-bit operand slice to its weighted residue (slice·2^(6k) mod 997). This block receives those residues serially over a valid/ready stream.
- It accumulates them modulo 997 and presents the final residue of the whole 500-bit operand downstream.

Parameters:
- MODULUS, 997, modulus; all accumulation is mod MODULUS.
- RES_W, 10, residue width; must satisfy 2^RES_W < 2*MODULUS.
- NUM_CHUNKS, 84, expected beats per operand (ceil(500/6)).
- CNT_W, 7, beat-counter width; must satisfy 2^CNT_W > NUM_CHUNKS.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  residue beat present.
- in_ready  out  1  block accepts a beat.
- in_residue  in  RES_W  chunk residue; normally < MODULUS; values up to 2^RES_W-1 are tolerated.
- in_last  in  1  marks the final beat of the operand.
- flush  in  1  synchronous abort; discards any partial sum.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts the result.
- out_residue  out  RES_W  final residue, always < MODULUS.
- out_err  out  1  beat-count mismatch flag; qualified by out_valid.

Behaviour:
- Reset (async, rst_n=0): state=ACC, acc=0, cnt=0, out_valid=0, out_residue=0, out_err=0, in_ready=1.
- States: ACC and DONE.
- ACC:
  - in_ready=1.
  - Beat = in_valid&in_ready.
  - On a beat: r = in_residue, minus MODULUS if in_residue >= MODULUS. s = acc + r (RES_W+1 bits). acc_next = s - MODULUS if s >= MODULUS, else s. cnt increments.
- ACC with a beat and in_last=1:
  - out_residue <= acc_next; out_valid <= 1; state -> DONE.
  - Latency: result is visible the cycle after the last beat.
- DONE:
  - in_ready=0. out_residue and out_err are held stable while out_valid=1 and out_ready=0.
  - On out_valid&out_ready: out_valid <= 0; acc <= 0; cnt <= 0; state -> ACC.
  - A new beat can therefore be accepted at the earliest one cycle after the handshake.
- flush=1 (any state): acc=0, cnt=0, out_valid=0, out_err=0, state -> ACC. Flush has priority over a beat or handshake in the same cycle.
- Single-beat operand (in_last on the first beat): result = reduced r.
- cnt saturates at 2^CNT_W-1 and never wraps.
- Reset asserted mid-operation clears everything immediately; the partial sum is lost and no output is produced.
- Combinational paths: in_ready depends only on state; it has no dependence on out_ready.

Optional Feature:
- Macro: MOD997_ACCUM_CNT_CHECK_EN.
- Defined:
  - On the in_last beat, out_err <= (cnt+1 != NUM_CHUNKS).
  - A beat arriving when cnt+1 == NUM_CHUNKS with in_last=0 sets a sticky err. The block keeps accumulating, and err is reported with the eventual result.
- Not defined: the counter is removed and out_err is tied to 0.

Decomposition:
- Package mod997_pkg holds:
  - localparams MOD997=997, RES_W=10, NUM_CHUNKS=84.
  - typedef residue_t (logic [RES_W-1:0]).
  - typedef state_e {ACC, DONE}.
  - function canon(r): single conditional subtract.
- One combinational sub-module, mod997_add: inputs two canonical residues, output (a+b) mod 997 via an 11-bit add and a conditional subtract. It is reused by later parallel-tree variants.

Test Plan:
- Beats 500, 600(last) -> out_residue=103, out_valid one cycle after the last beat.
- Beats 996, 996(last) -> 995.
- Non-canonical input: beats 1000, 0(last) -> 3.
- 84 beats of value 1, last on the 84th -> out_residue=84, out_err=0. With the macro, 3 beats ending in last -> out_err=1. Without the macro, the same stimulus -> out_err=0.
- Backpressure: out_ready=0 for 5 cycles after the result -> out_valid and out_residue stable, in_ready=0. Raise out_ready -> in_ready=1 next cycle, acc=0.
- Two beats (100, 200) then rst_n=0 for 1 cycle -> out_valid=0. A subsequent single beat 7(last) -> 7.
- flush after partial beats (400, 400) -> a following single beat 5(last) yields 5.
